// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge.
// State encoding, default widths and SPI register bank addresses.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_t;

    localparam int ADDR_W_DEF  = 8;
    localparam int WDATA_W_DEF = 8;
    localparam int RDATA_W_DEF = 16;

    localparam logic [7:0] SPI_CTRL   = 8'h00;
    localparam logic [7:0] SPI_STATUS = 8'h04;
    localparam logic [7:0] SPI_RXDATA = 8'h08;
    localparam logic [7:0] SPI_TXDATA = 8'h0C;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response stream plus APB bus bundle for the APB master bridge.
// master = bridge side, slave = controller/responder side.
interface apb_master_bridge_if
    import apb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int WDATA_W = WDATA_W_DEF,
    parameter int RDATA_W = RDATA_W_DEF
) ();

    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_write;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [WDATA_W-1:0] cmd_wdata;
    logic               rsp_valid;
    logic [RDATA_W-1:0] rsp_rdata;
    logic               rsp_err;
    logic               PSEL;
    logic               PENABLE;
    logic               PWRITE;
    logic [ADDR_W-1:0]  PADDR;
    logic [WDATA_W-1:0] PWDATA;
    logic [RDATA_W-1:0] PRDATA;
    logic               PREADY;
    logic               PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/apb_master_wdog.sv
// ACCESS-phase wait counter for the APB master bridge.
// Flags expiry on the LIMIT-th consecutive wait cycle.
module apb_master_wdog #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    // count wait cycles, restart for every new transfer
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != CW'(LIMIT))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = inc && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: valid/ready commands -> APB SETUP/ACCESS, one rsp each.
// Optional ACCESS timeout when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int WDATA_W        = WDATA_W_DEF,
    parameter int RDATA_W        = RDATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_master_bridge_if.master bus
);

    state_t             state_q;
    state_t             state_d;
    logic               accept;
    logic               complete;
    logic               tmo;
    logic               cmd_ready;

    logic               psel_q, psel_d;
    logic               penable_q, penable_d;
    logic               pwrite_q;
    logic [ADDR_W-1:0]  paddr_q;
    logic [WDATA_W-1:0] pwdata_q;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [RDATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    assign cmd_ready = (state_q == IDLE) ||
                       ((state_q == ACCESS) && bus.PREADY);
    assign accept    = bus.cmd_valid && cmd_ready;
    assign complete  = (state_q == ACCESS) && bus.PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
    logic wd_clr;
    logic wd_inc;

    assign wd_clr = (state_q == SETUP);
    assign wd_inc = (state_q == ACCESS) && !bus.PREADY;

    apb_master_wdog #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (PCLK),
        .rst     (PRESET),
        .clr     (wd_clr),
        .inc     (wd_inc),
        .expired (tmo)
    );
`else
    assign tmo = 1'b0;
`endif

    // state and registered bus/response outputs
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            if (accept) begin
                pwrite_q <= bus.cmd_write;
                paddr_q  <= bus.cmd_addr;
                pwdata_q <= bus.cmd_wdata;
            end
        end
    end

    // next-state: PREADY beats an expiring timeout in the same cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = accept ? SETUP : IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS: begin
                if (bus.PREADY)
                    state_d = bus.cmd_valid ? SETUP : IDLE;
                else if (tmo)
                    state_d = IDLE;
                else
                    state_d = ACCESS;
            end
            default: state_d = IDLE;
        endcase
    end

    // next values of the registered outputs
    always_comb begin
        psel_d      = (state_d != IDLE);
        penable_d   = (state_d == ACCESS);
        rsp_valid_d = complete || tmo;
        rsp_err_d   = complete ? bus.PSLVERR : tmo;
        rsp_rdata_d = (complete && !pwrite_q) ? bus.PRDATA : '0;
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule
